angle_hex_display: RTL

//   Downstream consumer of the CORDIC tilt-angle stage. Samples the signed integer angle
//   (degrees) at a fixed refresh rate, converts its magnitude to BCD by serial double-dabble,
//   and drives four DE10-Lite seven-segment displays as sign/hundreds/tens/ones with

---
 rtl/angle_hex_display.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/angle_hex_display.sv
// angle_hex_display
//   Periodically samples a signed tilt angle (degrees), converts its magnitude to BCD with a
//   serial double-dabble, and drives four active-low seven-segment digits as
//   sign / hundreds / tens / ones with leading-zero blanking.
//
// Parameters
//   ANGLE_W      width of the two's-complement input angle (<= 10 so three BCD digits suffice)
//   REFRESH_DIV  i_clk cycles per refresh period (minimum 16)
//
// Ports
//   i_clk     system clock
//   i_rst_n   asynchronous active-low reset
//   i_angle   signed angle in degrees
//   i_valid   i_angle is valid this cycle
//   o_hex3    sign digit       {dp,g,f,e,d,c,b,a}, active low
//   o_hex2    hundreds digit   same encoding
//   o_hex1    tens digit       same encoding
//   o_hex0    ones digit       same encoding
//   o_busy    a conversion is in progress (LOAD, SHIFT or DONE)
//   o_update  one-cycle pulse in the cycle the hex outputs take new values

module angle_hex_display #(
   parameter int unsigned ANGLE_W     = 9,
   parameter int unsigned REFRESH_DIV = 5000000
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [ANGLE_W-1:0] i_angle,
   input  logic               i_valid,
   output logic [7:0]         o_hex3,
   output logic [7:0]         o_hex2,
   output logic [7:0]         o_hex1,
   output logic [7:0]         o_hex0,
   output logic               o_busy,
   output logic               o_update
);

   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
   localparam int unsigned BIT_W = $clog2(ANGLE_W);
   // Three BCD digits cover magnitudes up to 999.
   localparam int unsigned BCD_W = 12;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(ANGLE_W - 1);

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_MINUS = 8'hBF;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StLoad  = 2'd1;
   localparam logic [1:0] StShift = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   // Digit 0..9 to active-low segments with the decimal point off.
   function automatic logic [7:0] seg7(input logic [3:0] digit);
      logic [7:0] seg;
      case (digit)
         4'd0:    seg = 8'hC0;
         4'd1:    seg = 8'hF9;
         4'd2:    seg = 8'hA4;
         4'd3:    seg = 8'hB0;
         4'd4:    seg = 8'h99;
         4'd5:    seg = 8'h92;
         4'd6:    seg = 8'h82;
         4'd7:    seg = 8'hF8;
         4'd8:    seg = 8'h80;
         4'd9:    seg = 8'h90;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

   logic [1:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               pending_q, pending_d;
   logic [ANGLE_W-1:0] angle_q, angle_d;
   logic               sign_q, sign_d;
   logic [ANGLE_W-1:0] mag_q, mag_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [7:0]         hex3_q, hex3_d;
   logic [7:0]         hex2_q, hex2_d;
   logic [7:0]         hex1_q, hex1_d;
   logic [7:0]         hex0_q, hex0_d;
   logic               update_q, update_d;

   logic               wrap;
   logic               capture;
   logic [BCD_W-1:0]   bcd_adj;
   logic [3:0]         dig_hund;
   logic [3:0]         dig_tens;
   logic [3:0]         dig_ones;

   // ------------------------------------------------------------------
   // Refresh timebase and pending request
   // ------------------------------------------------------------------
   always_comb begin
      wrap  = (cnt_q == CNT_LAST);
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      // A new refresh tick wins over a capture on the same edge, so at most one request is
      // ever outstanding and a tick is never lost.
      if (wrap) begin
         pending_d = 1'b1;
      end else if (capture) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end
   end

   // ------------------------------------------------------------------
   // Double-dabble add-3 correction applied before each shift
   // ------------------------------------------------------------------
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < BCD_W / 4; i++) begin
         if (bcd_adj[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
         end
      end
   end

   assign dig_hund = bcd_q[11:8];
   assign dig_tens = bcd_q[7:4];
   assign dig_ones = bcd_q[3:0];

   // ------------------------------------------------------------------
   // Conversion FSM next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      angle_d  = angle_q;
      sign_d   = sign_q;
      mag_d    = mag_q;
      bcd_d    = bcd_q;
      bit_d    = bit_q;
      hex3_d   = hex3_q;
      hex2_d   = hex2_q;
      hex1_d   = hex1_q;
      hex0_d   = hex0_q;
      update_d = 1'b0;
      capture  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (pending_q && i_valid) begin
               angle_d = i_angle;
               capture = 1'b1;
               state_d = StLoad;
            end
         end

         StLoad: begin
            sign_d  = angle_q[ANGLE_W-1];
            // Unsigned ANGLE_W-bit negate: the most negative value maps to its true magnitude.
            mag_d   = angle_q[ANGLE_W-1] ? (~angle_q + ANGLE_W'(1)) : angle_q;
            bcd_d   = '0;
            bit_d   = '0;
            state_d = StShift;
         end

         StShift: begin
            {bcd_d, mag_d} = {bcd_adj[BCD_W-2:0], mag_q, 1'b0};
            bit_d          = bit_q + BIT_W'(1);
            if (bit_q == BIT_LAST) begin
               state_d = StDone;
            end
         end

         StDone: begin
            // Zero is never negative in two's complement, so the sign bit alone decides.
            hex3_d   = sign_q ? SEG_MINUS : SEG_BLANK;
            hex2_d   = (dig_hund == 4'd0) ? SEG_BLANK : seg7(dig_hund);
            hex1_d   = (dig_hund == 4'd0 && dig_tens == 4'd0) ? SEG_BLANK : seg7(dig_tens);
            hex0_d   = seg7(dig_ones);
            update_d = 1'b1;
            state_d  = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         pending_q <= 1'b0;
         angle_q   <= '0;
         sign_q    <= 1'b0;
         mag_q     <= '0;
         bcd_q     <= '0;
         bit_q     <= '0;
         hex3_q    <= SEG_BLANK;
         hex2_q    <= SEG_BLANK;
         hex1_q    <= SEG_BLANK;
         hex0_q    <= SEG_BLANK;
         update_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         angle_q   <= angle_d;
         sign_q    <= sign_d;
         mag_q     <= mag_d;
         bcd_q     <= bcd_d;
         bit_q     <= bit_d;
         hex3_q    <= hex3_d;
         hex2_q    <= hex2_d;
         hex1_q    <= hex1_d;
         hex0_q    <= hex0_d;
         update_q  <= update_d;
      end
   end

   assign o_hex3   = hex3_q;
   assign o_hex2   = hex2_q;
   assign o_hex1   = hex1_q;
   assign o_hex0   = hex0_q;
   assign o_busy   = (state_q != StIdle);
   assign o_update = update_q;

endmodule
